// File: rtl/obg_frame_gen.sv
// ---------------------------------------------------------------------------
// obg_frame_gen
//   Original-bits generator for the OFDM TX chain. Serialises the 24-bit
//   SIGNAL field and then emits the PSDU payload, DW bits per beat, under a
//   valid/ready handshake. Payload is either an internal PRBS (x^7+x^4+1,
//   reseeded at every frame start) or an external byte stream through a
//   one-byte holding register.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   di_len          PSDU length in bytes (0 = SIGNAL only)
//   di_rate         RATE field
//   di_mode         0 = PRBS payload, 1 = external payload bytes
//   di_vld/di_rdy   frame request handshake (di_rdy high only in IDLE)
//   pld_di          external payload byte, LSB sent first
//   pld_di_vld/rdy  external byte handshake (pld_di_rdy is combinational)
//   do_dat          output bits, do_dat[0] earliest in time
//   do_vld/do_rdy   output beat handshake
//   do_sig          beat belongs to the SIGNAL field
//   do_sof          first SIGNAL beat
//   do_eof          last beat of the frame
//   done            one-cycle pulse after the last beat transfers
// ---------------------------------------------------------------------------
module obg_frame_gen #(
    parameter int unsigned DW        = 1,
    parameter int unsigned LEN_W     = 12,
    parameter logic [6:0]  PRBS_SEED = 7'h7F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] di_len,
    input  logic [3:0]       di_rate,
    input  logic             di_mode,
    input  logic             di_vld,
    output logic             di_rdy,
    input  logic [7:0]       pld_di,
    input  logic             pld_di_vld,
    output logic             pld_di_rdy,
    output logic [DW-1:0]    do_dat,
    output logic             do_vld,
    input  logic             do_rdy,
    output logic             do_sig,
    output logic             do_sof,
    output logic             do_eof,
    output logic             done
);

    localparam int unsigned DW_LOG    = $clog2(DW);
    localparam int unsigned SIG_BEATS = 24 / DW;
    localparam int unsigned BPB       = 8 / DW;
    localparam int unsigned CW        = LEN_W + 3;
    localparam logic [2:0]  SUB_LAST  = 3'(BPB - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SIG,
        ST_PLD,
        ST_DONE
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic             mode_q;
    logic [23:0]      sig_sr;
    logic [4:0]       sig_idx;
    logic [CW-1:0]    pld_cnt;
    logic [LEN_W-1:0] byte_cnt;
    logic [7:0]       byte_sr;
    logic [2:0]       sub_cnt;
    logic [6:0]       lfsr;

    logic [11:0]      len12_c;
    logic [23:0]      sig_word_c;
    logic [CW-1:0]    total_beats_c;
    logic             pld_last_c;
    logic [DW-1:0]    prbs_bits_c;
    logic [6:0]       lfsr_nxt_c;
    logic             byte_take_c;

    // SIGNAL word built from the live request inputs; latched into sig_sr on accept
    always_comb begin
        len12_c    = 12'(di_len);
        sig_word_c = {6'b0, ^{len12_c, 1'b0, di_rate}, len12_c, 1'b0, di_rate};
    end

    // Payload beat count and "beat being loaded is the last one"
    always_comb begin
        total_beats_c = CW'({len_q, 3'b000} >> DW_LOG);
        pld_last_c    = (pld_cnt == total_beats_c - CW'(1));
    end

    // Next DW PRBS bits and the LFSR state after them
    always_comb begin
        logic [6:0] s;
        s           = lfsr;
        prbs_bits_c = '0;
        for (int i = 0; i < int'(DW); i++) begin
            prbs_bits_c[i] = s[6] ^ s[3];
            s              = {s[5:0], prbs_bits_c[i]};
        end
        lfsr_nxt_c = s;
    end

    // Holding register can take a byte when empty or when its last beat leaves now
    assign pld_di_rdy  = (state == ST_PLD) && mode_q && (byte_cnt < len_q) &&
                         (!do_vld || (do_rdy && (sub_cnt == SUB_LAST)));
    assign byte_take_c = pld_di_vld && pld_di_rdy;

    // Frame FSM; output registers always hold the beat currently offered
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            di_rdy   <= 1'b0;
            do_vld   <= 1'b0;
            do_dat   <= '0;
            do_sig   <= 1'b0;
            do_sof   <= 1'b0;
            do_eof   <= 1'b0;
            done     <= 1'b0;
            lfsr     <= PRBS_SEED;
            len_q    <= '0;
            mode_q   <= 1'b0;
            sig_sr   <= '0;
            sig_idx  <= '0;
            pld_cnt  <= '0;
            byte_cnt <= '0;
            byte_sr  <= '0;
            sub_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    di_rdy <= 1'b1;
                    if (di_vld && di_rdy) begin
                        state    <= ST_SIG;
                        di_rdy   <= 1'b0;
                        len_q    <= di_len;
                        mode_q   <= di_mode;
                        lfsr     <= PRBS_SEED;
                        do_vld   <= 1'b1;
                        do_dat   <= sig_word_c[DW-1:0];
                        sig_sr   <= sig_word_c >> DW;
                        do_sig   <= 1'b1;
                        do_sof   <= 1'b1;
                        do_eof   <= 1'b0;
                        sig_idx  <= '0;
                        pld_cnt  <= '0;
                        byte_cnt <= '0;
                        sub_cnt  <= '0;
                    end
                end

                ST_SIG: begin
                    if (do_rdy) begin
                        do_sof <= 1'b0;
                        if (sig_idx == 5'(SIG_BEATS - 1)) begin
                            do_sig <= 1'b0;
                            if (len_q == '0) begin
                                state  <= ST_DONE;
                                done   <= 1'b1;
                                do_vld <= 1'b0;
                                do_eof <= 1'b0;
                                do_dat <= '0;
                            end else begin
                                state <= ST_PLD;
                                if (mode_q) begin
                                    // wait for the first external byte
                                    do_vld <= 1'b0;
                                    do_eof <= 1'b0;
                                end else begin
                                    do_vld  <= 1'b1;
                                    do_dat  <= prbs_bits_c;
                                    lfsr    <= lfsr_nxt_c;
                                    do_eof  <= (total_beats_c == CW'(1));
                                    pld_cnt <= CW'(1);
                                end
                            end
                        end else begin
                            sig_idx <= sig_idx + 5'd1;
                            do_dat  <= sig_sr[DW-1:0];
                            sig_sr  <= sig_sr >> DW;
                            do_eof  <= (sig_idx == 5'(SIG_BEATS - 2)) && (len_q == '0);
                        end
                    end
                end

                ST_PLD: begin
                    if (do_vld && do_rdy && do_eof) begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        do_vld <= 1'b0;
                        do_eof <= 1'b0;
                        do_dat <= '0;
                    end else if (byte_take_c) begin
                        do_vld   <= 1'b1;
                        do_dat   <= pld_di[DW-1:0];
                        byte_sr  <= pld_di >> DW;
                        sub_cnt  <= '0;
                        byte_cnt <= byte_cnt + LEN_W'(1);
                        do_eof   <= pld_last_c;
                        pld_cnt  <= pld_cnt + CW'(1);
                    end else if (do_vld && do_rdy) begin
                        if (!mode_q) begin
                            do_dat  <= prbs_bits_c;
                            lfsr    <= lfsr_nxt_c;
                            do_eof  <= pld_last_c;
                            pld_cnt <= pld_cnt + CW'(1);
                        end else if (sub_cnt != SUB_LAST) begin
                            do_dat  <= byte_sr[DW-1:0];
                            byte_sr <= byte_sr >> DW;
                            sub_cnt <= sub_cnt + 3'd1;
                            do_eof  <= pld_last_c;
                            pld_cnt <= pld_cnt + CW'(1);
                        end else begin
                            // byte drained and no new one offered: bubble
                            do_vld <= 1'b0;
                        end
                    end
                end

                ST_DONE: begin
                    state  <= ST_IDLE;
                    di_rdy <= 1'b1;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obg_frame_gen.sv
// ---------------------------------------------------------------------------
// tb_obg_frame_gen
//   Self-checking bench for obg_frame_gen. Four instances (DW = 1, 2, 4, 8)
//   share all inputs; sel picks the instance whose outputs are observed.
//   Expected beats come from a bit-level model of the SIGNAL word and payload.
// ---------------------------------------------------------------------------
module tb_obg_frame_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [11:0] di_len;
    logic [3:0]  di_rate;
    logic        di_mode;
    logic        di_vld;
    logic [7:0]  pld_di;
    logic        pld_di_vld;
    logic        do_rdy;

    logic [3:0]  di_rdy_v, pld_rdy_v, vld_v, sig_v, sof_v, eof_v, done_v;
    logic [0:0]  d1;
    logic [1:0]  d2;
    logic [3:0]  d4;
    logic [7:0]  d8;

    int          sel;
    logic [7:0]  m_dat;
    logic        m_vld, m_sig, m_sof, m_eof, m_done, m_di_rdy, m_pld_rdy;

    int          n_pass = 0;
    int          n_chk  = 0;
    int          exp_q[$];
    logic [7:0]  ext_bytes[$];
    logic [7:0]  first8;

    obg_frame_gen #(.DW(1), .LEN_W(12), .PRBS_SEED(7'h7F)) u_dut1 (
        .clk(clk), .rst(rst), .di_len(di_len), .di_rate(di_rate), .di_mode(di_mode),
        .di_vld(di_vld), .di_rdy(di_rdy_v[0]), .pld_di(pld_di), .pld_di_vld(pld_di_vld),
        .pld_di_rdy(pld_rdy_v[0]), .do_dat(d1), .do_vld(vld_v[0]), .do_rdy(do_rdy),
        .do_sig(sig_v[0]), .do_sof(sof_v[0]), .do_eof(eof_v[0]), .done(done_v[0]));

    obg_frame_gen #(.DW(2), .LEN_W(12), .PRBS_SEED(7'h7F)) u_dut2 (
        .clk(clk), .rst(rst), .di_len(di_len), .di_rate(di_rate), .di_mode(di_mode),
        .di_vld(di_vld), .di_rdy(di_rdy_v[1]), .pld_di(pld_di), .pld_di_vld(pld_di_vld),
        .pld_di_rdy(pld_rdy_v[1]), .do_dat(d2), .do_vld(vld_v[1]), .do_rdy(do_rdy),
        .do_sig(sig_v[1]), .do_sof(sof_v[1]), .do_eof(eof_v[1]), .done(done_v[1]));

    obg_frame_gen #(.DW(4), .LEN_W(12), .PRBS_SEED(7'h7F)) u_dut4 (
        .clk(clk), .rst(rst), .di_len(di_len), .di_rate(di_rate), .di_mode(di_mode),
        .di_vld(di_vld), .di_rdy(di_rdy_v[2]), .pld_di(pld_di), .pld_di_vld(pld_di_vld),
        .pld_di_rdy(pld_rdy_v[2]), .do_dat(d4), .do_vld(vld_v[2]), .do_rdy(do_rdy),
        .do_sig(sig_v[2]), .do_sof(sof_v[2]), .do_eof(eof_v[2]), .done(done_v[2]));

    obg_frame_gen #(.DW(8), .LEN_W(12), .PRBS_SEED(7'h7F)) u_dut8 (
        .clk(clk), .rst(rst), .di_len(di_len), .di_rate(di_rate), .di_mode(di_mode),
        .di_vld(di_vld), .di_rdy(di_rdy_v[3]), .pld_di(pld_di), .pld_di_vld(pld_di_vld),
        .pld_di_rdy(pld_rdy_v[3]), .do_dat(d8), .do_vld(vld_v[3]), .do_rdy(do_rdy),
        .do_sig(sig_v[3]), .do_sof(sof_v[3]), .do_eof(eof_v[3]), .done(done_v[3]));

    // Observation mux onto the selected instance
    always_comb begin
        case (sel)
            0:       m_dat = 8'(d1);
            1:       m_dat = 8'(d2);
            2:       m_dat = 8'(d4);
            default: m_dat = d8;
        endcase
        m_vld     = vld_v[sel];
        m_sig     = sig_v[sel];
        m_sof     = sof_v[sel];
        m_eof     = eof_v[sel];
        m_done    = done_v[sel];
        m_di_rdy  = di_rdy_v[sel];
        m_pld_rdy = pld_rdy_v[sel];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference: whole frame as a bit list, then cut into DW-bit beats
    function automatic void build_exp(input int dw, input int len, input int rate, input bit mode);
        bit          bits[$];
        logic [11:0] l12;
        logic [3:0]  r4;
        logic [23:0] s;
        logic [6:0]  lf;
        bit          b;
        int          v;
        l12 = len[11:0];
        r4  = rate[3:0];
        s   = {6'b0, ^{l12, 1'b0, r4}, l12, 1'b0, r4};
        for (int i = 0; i < 24; i++) bits.push_back(s[i]);
        if (!mode) begin
            lf = 7'h7F;
            for (int i = 0; i < len * 8; i++) begin
                b  = lf[6] ^ lf[3];
                bits.push_back(b);
                lf = {lf[5:0], b};
            end
        end else begin
            for (int j = 0; j < len; j++)
                for (int i = 0; i < 8; i++) bits.push_back(ext_bytes[j][i]);
        end
        exp_q.delete();
        for (int k = 0; k < bits.size() / dw; k++) begin
            v = 0;
            for (int j = 0; j < dw; j++) v = v | (int'(bits[k*dw + j]) << j);
            exp_q.push_back(v);
        end
    endfunction

    task automatic fill_bytes(input int len);
        ext_bytes.delete();
        for (int i = 0; i < len; i++) ext_bytes.push_back(8'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; di_vld = 1'b0; pld_di_vld = 1'b0; do_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One frame on the selected instance; returns early after abort_k beats if abort_k > 0
    task automatic run_frame(input int len, input int rate, input bit mode, input int rdy_pct,
                             input int starve_pct, input int abort_k, input bit keep_vld);
        int  dw, nsig, nb, k, bi, cyc, gaps;
        bit  prev_stall, seen_done;
        logic [7:0] p_dat;
        logic [2:0] p_fl;
        dw = 1 << sel; nsig = 24 / dw;
        k = 0; bi = 0; cyc = 0; gaps = 0; prev_stall = 0; seen_done = 0;
        p_dat = '0; p_fl = '0;
        build_exp(dw, len, rate, mode);
        nb = exp_q.size();

        @(negedge clk);
        di_len = 12'(len); di_rate = 4'(rate); di_mode = mode; di_vld = 1'b1;
        #1;
        while (!m_di_rdy && cyc < 50) begin
            @(negedge clk); #1; cyc++;
        end
        chk("req_accept", 64'(cyc < 50), 64'd1);
        if (cyc >= 50) begin di_vld = 1'b0; return; end

        @(negedge clk);
        if (!keep_vld) di_vld = 1'b0;
        chk("sof_latency", {m_vld, m_sof, m_sig}, 3'b111);
        // request inputs moving mid-frame must not matter
        di_len = 12'($urandom); di_rate = 4'($urandom); di_mode = 1'($urandom);

        cyc = 0;
        while (cyc < 20000) begin
            if (prev_stall) chk("stall_hold", {m_dat, m_sig, m_sof, m_eof}, {p_dat, p_fl});
            if (m_done) begin
                seen_done = 1;
                chk("done_after_last", 64'(k), 64'(nb));
                chk("done_vld", m_vld, 1'b0);
                break;
            end
            chk("busy_di_rdy", m_di_rdy, 1'b0);
            do_rdy     = ($urandom_range(99) < rdy_pct);
            pld_di_vld = mode && (bi < len) && ($urandom_range(99) >= starve_pct);
            pld_di     = (bi < len) ? ext_bytes[bi] : 8'($urandom);
            #1;
            if (!mode || bi >= len) chk("pld_rdy_off", m_pld_rdy, 1'b0);
            if (m_vld && do_rdy) begin
                if (k < nb) begin
                    chk("beat_dat", m_dat, 64'(exp_q[k]));
                    chk("beat_flags", {m_sig, m_sof, m_eof}, {k < nsig, k == 0, k == nb - 1});
                    if (dw == 1 && k >= nsig && k < nsig + 8) first8[k - nsig] = m_dat[0];
                end else begin
                    chk("extra_beat", 64'(k), 64'(nb - 1));
                end
                k++;
                if (abort_k > 0 && k == abort_k) return;
            end
            if (mode && pld_di_vld && m_pld_rdy) bi++;
            if (!m_vld && k >= nsig && k < nb) gaps++;
            prev_stall = m_vld && !do_rdy;
            p_dat      = m_dat;
            p_fl       = {m_sig, m_sof, m_eof};
            @(negedge clk);
            cyc++;
        end
        chk("frame_timeout", 64'(seen_done), 64'd1);
        if (mode) chk("bytes_taken", 64'(bi), 64'(len));
        if (starve_pct > 0 && mode) chk("starve_gaps", 64'(gaps > 0), 64'd1);
        @(negedge clk);
        chk("done_pulse", m_done, 1'b0);
        chk("idle_di_rdy", m_di_rdy, 1'b1);
    endtask

    initial begin
        int s;
        rst = 1'b1; di_len = '0; di_rate = '0; di_mode = 1'b0; di_vld = 1'b0;
        pld_di = '0; pld_di_vld = 1'b0; do_rdy = 1'b0; sel = 0; first8 = '0;

        // reset values
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sel = i; #1;
            chk("rst_outs", {m_vld, m_sig, m_sof, m_eof, m_done, m_di_rdy, m_pld_rdy, m_dat}, 64'd0);
        end
        sel = 0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_di_rdy", m_di_rdy, 1'b1);

        // DW=1, rate 1101, len 100, PRBS
        run_frame(100, 13, 1'b0, 100, 0, 0, 1'b0);
        chk("prbs_first8", first8, 8'h70);

        // same instance again without reset: PRBS must reseed per frame
        run_frame(3, 5, 1'b0, 100, 0, 0, 1'b0);

        // DW=8, len 0
        sel = 3; do_reset();
        run_frame(0, $urandom_range(15), 1'b0, 100, 0, 0, 1'b0);

        // DW=4, external bytes A5, 3C with starvation
        sel = 2; do_reset();
        ext_bytes.delete(); ext_bytes.push_back(8'hA5); ext_bytes.push_back(8'h3C);
        run_frame(2, 11, 1'b1, 100, 60, 0, 1'b0);

        // DW=2 with 50% back-pressure, PRBS and external
        sel = 1; do_reset();
        run_frame(30, 9, 1'b0, 50, 0, 0, 1'b0);
        fill_bytes(10);
        run_frame(10, 6, 1'b1, 50, 30, 0, 1'b0);

        // reset mid-payload, then a fresh frame
        sel = 0; do_reset();
        run_frame(10, 3, 1'b0, 100, 0, 24 + 20, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outs", {m_vld, m_sig, m_sof, m_eof, m_done, m_di_rdy, m_dat}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        run_frame(4, 3, 1'b0, 100, 0, 0, 1'b0);

        // di_vld held through a frame: next frame one cycle after IDLE
        sel = 2; do_reset();
        run_frame(3, 7, 1'b0, 70, 0, 0, 1'b1);
        @(negedge clk);
        chk("hold_restart", {m_vld, m_sof}, 2'b11);
        di_vld = 1'b0;

        // randomized frames
        for (int f = 0; f < 12; f++) begin
            s = int'($urandom_range(3));
            if (s != sel || f == 0) begin sel = s; do_reset(); end
            begin
                int  len, rate, rp, sp;
                bit  md;
                len  = int'($urandom_range(24));
                rate = int'($urandom_range(15));
                md   = 1'($urandom);
                rp   = int'($urandom_range(100, 30));
                sp   = int'($urandom_range(50));
                if (md) fill_bytes(len);
                run_frame(len, rate, md, rp, sp, 0, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
